// File: rtl/eem16_seq_pkg.sv
// Shared types and width helpers for the eem16 serial sequence transmitter.
package eem16_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int MAX_WIDTH = 16;
    localparam int MAX_GAP   = 15;

    localparam int CNT_W_MAX = $clog2(MAX_WIDTH + 1);
    localparam int GAP_W_MAX = $clog2(MAX_GAP + 1);

    // Width of a counter able to hold 0..w inclusive.
    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction

    // Gap counter never goes below one bit, even when no gap is configured.
    function automatic int gap_cnt_width(input int g);
        return (g < 1) ? 1 : $clog2(g + 1);
    endfunction

endpackage

// File: rtl/eem16_piso.sv
// WIDTH-bit parallel-in/serial-out shift register, MSB first.
module eem16_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb,
    output logic             next_msb
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[WIDTH-2:0], 1'b0};
        end
    end

    // next_msb lets the caller register the upcoming symbol in the same edge as the shift.
    assign msb      = sr[WIDTH-1];
    assign next_msb = sr[WIDTH-2];

endmodule

// File: rtl/eem16_seq_tx.sv
// Serial sequence transmitter: shifts a loaded pattern out on the x0 strobe / x1 value pair.
module eem16_seq_tx
    import eem16_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [WIDTH-1:0]             data,
    input  logic [$clog2(WIDTH+1)-1:0]   count,
    input  logic                         abort,
    output logic                         x0,
    output logic                         x1,
    output logic                         ready,
    output logic                         done
);

    localparam int CW = count_width(WIDTH);
    localparam int GW = gap_cnt_width(GAP);

    state_t          state;
    logic [CW-1:0]   bits_left;
    logic [GW-1:0]   gap_cnt;
    logic [CW-1:0]   count_clamped;
    logic            accept;
    logic            sr_shift;
    logic            sr_msb;
    logic            sr_next_msb;

    assign count_clamped = (count > CW'(WIDTH)) ? CW'(WIDTH) : count;
    assign accept        = (state == S_IDLE) && start && !abort && (count != '0);
    assign sr_shift      = (state == S_SEND) && !abort;
    assign ready         = (state == S_IDLE);

    eem16_piso #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .shift    (sr_shift),
        .din      (data),
        .msb      (sr_msb),
        .next_msb (sr_next_msb)
    );

    // x0/x1 are registered with the state so the strobe and value change on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            x0        <= 1'b0;
            x1        <= 1'b0;
            done      <= 1'b0;
            bits_left <= '0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        bits_left <= count_clamped;
                        x0        <= 1'b1;
                        x1        <= data[WIDTH-1];
                        state     <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (abort) begin
                        x0    <= 1'b0;
                        x1    <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        bits_left <= bits_left - CW'(1);
                        if (bits_left == CW'(1)) begin
                            x0    <= 1'b0;
                            x1    <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else if (GAP == 0) begin
                            x0 <= 1'b1;
                            x1 <= sr_next_msb;
                        end else begin
                            x0      <= 1'b0;
                            x1      <= 1'b0;
                            gap_cnt <= GW'(GAP);
                            state   <= S_GAP;
                        end
                    end
                end

                S_GAP: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (gap_cnt == GW'(1)) begin
                        x0    <= 1'b1;
                        x1    <= sr_msb;
                        state <= S_SEND;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    x0    <= 1'b0;
                    x1    <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
